accum_core: RTL and testbench
=============================

# accum_core

Parametrised accumulator micro-core: the next generation of the team's tiny accumulator CPU. Adds loadable program memory, an explicit fetch/execute FSM, halt, conditional branch on both zero and non-zero, a registered output strobe, and configurable datapath width and memory depth. It sits behind the Tiny Tapeout top-level wrapper, which maps its load port and outputs onto `ui_in`, `uio_in`, `uo_out` and `uio_out`.

## Interface
**Parameters**
- `DATA_W`, default 8: accumulator and output width.
- `IMM_W`, default 5: operand width. Instruction width `IW = 3 + IMM_W`. `IMM_W` must be at least `AW`.
- `DEPTH`, default 16: instruction memory words. Must be a power of 2. `AW = $clog2(DEPTH)`.

**Ports**
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `ena`, in, 1: global enable. When low, all state holds. Includes FSM, pc, acc, memory writes and `out_valid`.
- `start`, in, 1: start pulse. Honoured only in IDLE or HALT.
- `load_we`, in, 1: program-memory write strobe.
- `load_addr`, in, AW: write address.
- `load_data`, in, IW: instruction word, packed as `{opcode[2:0], operand[IMM_W-1:0]}`.
- `out_data`, out, DATA_W: last value written by OUT.
- `out_valid`, out, 1: single-cycle strobe, high for the cycle after an OUT executes.
- `busy`, out, 1: high in FETCH and EXEC.
- `halted`, out, 1: high in HALT.
- `pc_dbg`, out, AW: current program counter.

## Operation
**Opcodes**
- 0 ADD: acc += zero-extended imm.
- 1 SUB: acc -= zero-extended imm.
- 2 LDI: acc = imm.
- 3 JMP: pc = imm[AW-1:0].
- 4 BZ: branch to imm[AW-1:0] if acc == 0, else pc+1.
- 5 BNZ: branch to imm[AW-1:0] if acc != 0, else pc+1.
- 6 OUT: out_data = acc, pulse out_valid.
- 7 HLT: enter HALT.

**Arithmetic and addressing**
- All arithmetic wraps modulo 2^DATA_W.
- When IMM_W > DATA_W, LDI truncates imm to DATA_W bits.
- Non-branching ops set pc = pc+1, wrapping DEPTH-1 → 0.
- Branch and jump targets ignore operand bits above AW.

**FSM**
- IDLE: on `start`, go to FETCH with pc=0 and acc=0.
- FETCH: IR ← imem[pc]; go to EXEC.
- EXEC: execute IR. Go to FETCH, or to HALT on HLT.
- HALT: pc and acc hold. On `start`, go to FETCH with pc=0 and acc=0.

**Program load**
- `load_we` writes only in IDLE or HALT. Writes in FETCH or EXEC are silently dropped.
- A write and `start` in the same cycle: both take effect, and the first fetch sees the new word.
- Memory contents are not reset. Software loads memory before the first `start`.

**Reset**
- Asynchronous; any state → IDLE.
- pc=0, acc=0, IR=0, out_data=0, out_valid=0, busy=0, halted=0.
- Reset mid-instruction discards that instruction; no partial update.

## Timing
- `start` is sampled at edge E0. IR for pc=0 is loaded at E1. EXEC updates land at E2. Each instruction takes exactly 2 enabled cycles.
- OUT executing at edge E drives `out_data` and `out_valid` from E. `out_valid` drops at the next enabled edge.
- `ena` low stretches any cycle. `out_valid` holds its value while `ena` is low.
- `start` in FETCH or EXEC is ignored.
- `busy` and `halted` are registered state decodes, never both high.

## Configuration
`ACCUM_CORE_STEP_EN`
- **Defined:**
  - Adds input ports `step_mode` and `step`.
  - Adds state PAUSE, entered after EXEC when `step_mode`=1.
  - Leaves PAUSE to FETCH on a `step` pulse.
  - Program load is permitted in PAUSE.
  - HLT still goes to HALT.
- **Undefined:** no ports, no PAUSE; behaviour is identical to `step_mode`=0.

## Structure
- Package `accum_core_pkg`: opcode localparams `OP_ADD` through `OP_HLT`, FSM state enum, opcode-width constant.
- Sub-module `accum_core_imem`: DEPTH×IW register file with one synchronous write port (gated by `ena`) and one asynchronous read port. No reset.

## Test plan
- Load [LDI 1, ADD 2, OUT, HLT], pulse `start` → `out_valid` once with `out_data`=3 at edge E6, then `halted`=1 and `pc_dbg`=3.
- Load [LDI 3, SUB 1, OUT, BNZ 1, HLT] → `out_data` sequence 2, 1, 0 on three strobes, then HALT.
- DATA_W=8, load [LDI 0, SUB 1, OUT, HLT] → `out_data`=0xFF (wrap). Then load [LDI 31, ADD 31, ADD 31, OUT] → 93.
- During a run, drive `load_we` to address 0 with HLT, then `start` again after halt → original program reruns unchanged (write dropped).
- Drop `ena` for 5 cycles mid-EXEC → `pc_dbg`, acc and FSM frozen; results and cycle count unchanged apart from the 5-cycle stretch.
- Assert `rst_n` low mid-run → all outputs 0 and state IDLE immediately. After release, `start` reruns from pc=0. With `ACCUM_CORE_STEP_EN` and `step_mode`=1, exactly one instruction executes per `step` pulse.

Source files
------------

// File: rtl/accum_core_pkg.sv
// accum_core_pkg: opcode encodings and FSM state type shared by the
// accumulator micro-core and its instruction memory.
package accum_core_pkg;

  localparam int OPC_W = 3;

  localparam logic [OPC_W-1:0] OP_ADD = 3'd0;
  localparam logic [OPC_W-1:0] OP_SUB = 3'd1;
  localparam logic [OPC_W-1:0] OP_LDI = 3'd2;
  localparam logic [OPC_W-1:0] OP_JMP = 3'd3;
  localparam logic [OPC_W-1:0] OP_BZ  = 3'd4;
  localparam logic [OPC_W-1:0] OP_BNZ = 3'd5;
  localparam logic [OPC_W-1:0] OP_OUT = 3'd6;
  localparam logic [OPC_W-1:0] OP_HLT = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_HALT  = 3'd3,
    ST_PAUSE = 3'd4
  } state_t;

endpackage

// File: rtl/accum_core_imem.sv
// accum_core_imem: DEPTH x IW program store, one synchronous write port
// qualified by ena, one asynchronous read port. Contents are not reset.
module accum_core_imem #(
  parameter  int DEPTH = 16,
  parameter  int IW    = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          ena,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem [DEPTH];

  // Write port: only when globally enabled and the core permits loading.
  always_ff @(posedge clk) begin
    if (ena && we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/accum_core.sv
// accum_core: fetch/execute accumulator micro-core with loadable program
// memory. Build option ACCUM_CORE_STEP_EN adds step_mode/step ports and a
// PAUSE state for single-stepping.
//
// state | meaning
// IDLE  | after reset, waiting for start; program load allowed
// FETCH | IR <= imem[pc]
// EXEC  | execute IR, update acc/pc/out
// HALT  | HLT executed; pc/acc hold, load allowed, start reruns
// PAUSE | single-step hold after EXEC; load allowed, step resumes
module accum_core
  import accum_core_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int IMM_W  = 5,
  parameter  int DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH),
  localparam int IW     = OPC_W + IMM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
`ifdef ACCUM_CORE_STEP_EN
  input  logic              step_mode,
  input  logic              step,
`endif
  input  logic              load_we,
  input  logic [AW-1:0]     load_addr,
  input  logic [IW-1:0]     load_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              busy,
  output logic              halted,
  output logic [AW-1:0]     pc_dbg
);

  state_t            state, state_nxt;
  logic [AW-1:0]     pc, pc_nxt, pc_inc;
  logic [DATA_W-1:0] acc, acc_nxt, imm_ext;
  logic [IW-1:0]     ir, imem_rdata;
  logic [OPC_W-1:0]  ir_op;
  logic [IMM_W-1:0]  ir_imm;
  logic [AW-1:0]     ir_tgt;
  logic              load_ok, do_out, pause_req, step_go;

`ifdef ACCUM_CORE_STEP_EN
  assign pause_req = step_mode;
  assign step_go   = step;
`else
  assign pause_req = 1'b0;
  assign step_go   = 1'b0;
`endif

  assign ir_op   = ir[IW-1:IMM_W];
  assign ir_imm  = ir[IMM_W-1:0];
  assign ir_tgt  = ir_imm[AW-1:0];
  // Zero-extends or truncates the operand to the datapath width.
  assign imm_ext = DATA_W'(ir_imm);
  assign pc_inc  = pc + AW'(1);
  assign pc_dbg  = pc;
  assign load_ok = (state == ST_IDLE) || (state == ST_HALT) || (state == ST_PAUSE);

  accum_core_imem #(
    .DEPTH(DEPTH),
    .IW   (IW)
  ) u_imem (
    .clk  (clk),
    .ena  (ena),
    .we   (load_we && load_ok),
    .waddr(load_addr),
    .wdata(load_data),
    .raddr(pc),
    .rdata(imem_rdata)
  );

  // Next-state, pc and accumulator decode.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    acc_nxt   = acc;
    do_out    = 1'b0;
    case (state)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_nxt = ST_FETCH;
          pc_nxt    = '0;
          acc_nxt   = '0;
        end
      end
      ST_FETCH: state_nxt = ST_EXEC;
      ST_EXEC: begin
        state_nxt = pause_req ? ST_PAUSE : ST_FETCH;
        pc_nxt    = pc_inc;
        case (ir_op)
          OP_ADD: acc_nxt = acc + imm_ext;
          OP_SUB: acc_nxt = acc - imm_ext;
          OP_LDI: acc_nxt = imm_ext;
          OP_JMP: pc_nxt  = ir_tgt;
          OP_BZ:  if (acc == '0) pc_nxt = ir_tgt;
          OP_BNZ: if (acc != '0) pc_nxt = ir_tgt;
          OP_OUT: do_out  = 1'b1;
          OP_HLT: begin
            state_nxt = ST_HALT;
            pc_nxt    = pc;
          end
          default: ;
        endcase
      end
      ST_PAUSE: if (step_go) state_nxt = ST_FETCH;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Architectural state; everything holds while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pc        <= '0;
      acc       <= '0;
      ir        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      halted    <= 1'b0;
    end else if (ena) begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      acc       <= acc_nxt;
      if (state == ST_FETCH) ir <= imem_rdata;
      if (do_out) out_data <= acc;
      out_valid <= do_out;
      busy      <= (state_nxt == ST_FETCH) || (state_nxt == ST_EXEC);
      halted    <= (state_nxt == ST_HALT);
    end
  end

endmodule

// File: tb/tb_accum_core.sv
// tb_accum_core: table-driven and randomized self-checking bench for
// accum_core (default parameters). Expected output values, strobe edges
// and halt point come from an instruction-level interpreter of the ISA.
module tb_accum_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       start = 1'b0;
  logic       load_we = 1'b0;
  logic [3:0] load_addr = '0;
  logic [7:0] load_data = '0;
  logic [7:0] out_data;
  logic       out_valid, busy, halted;
  logic [3:0] pc_dbg;
`ifdef ACCUM_CORE_STEP_EN
  logic       step_mode = 1'b0;
  logic       step = 1'b0;
`endif

  accum_core dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .start    (start),
`ifdef ACCUM_CORE_STEP_EN
    .step_mode(step_mode),
    .step     (step),
`endif
    .load_we  (load_we),
    .load_addr(load_addr),
    .load_data(load_data),
    .out_data (out_data),
    .out_valid(out_valid),
    .busy     (busy),
    .halted   (halted),
    .pc_dbg   (pc_dbg)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic [7:0] cur_prog [16];
  int         exp_edge[$];
  logic [7:0] exp_val[$];
  int         exp_halt_edge;
  int         exp_halt_pc;

  typedef struct packed {
    logic [15:0][7:0] prog;
    logic [7:0]       nout;
    logic [2:0][7:0]  outs;
    logic [7:0]       hpc;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Instruction-level interpreter: each instruction costs two enabled edges
  // after the start edge, so instruction n executes at edge 2n+2.
  task automatic model();
    int pc, acc, op, imm;
    logic [7:0] w;
    exp_edge.delete();
    exp_val.delete();
    exp_halt_edge = -1;
    exp_halt_pc = -1;
    pc = 0;
    acc = 0;
    for (int n = 0; n < 300; n++) begin
      w = cur_prog[pc];
      op = int'(w[7:5]);
      imm = int'(w[4:0]);
      case (op)
        0: begin acc = (acc + imm) % 256; pc = (pc + 1) % 16; end
        1: begin acc = (acc - imm + 256) % 256; pc = (pc + 1) % 16; end
        2: begin acc = imm; pc = (pc + 1) % 16; end
        3: pc = imm % 16;
        4: pc = (acc == 0) ? imm % 16 : (pc + 1) % 16;
        5: pc = (acc != 0) ? imm % 16 : (pc + 1) % 16;
        6: begin
          exp_edge.push_back(2 * n + 2);
          exp_val.push_back(8'(acc));
          pc = (pc + 1) % 16;
        end
        default: begin
          exp_halt_edge = 2 * (n + 1);
          exp_halt_pc = pc;
          return;
        end
      endcase
    end
  endtask

  task automatic load_prog();
    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      load_we = 1'b1;
      load_addr = 4'(i);
      load_data = cur_prog[i];
      @(negedge clk);
    end
    load_we = 1'b0;
  endtask

  // Start a run, collect strobes until halted, compare with expectations.
  // stall_at > 0 drops ena for 5 cycles after that edge; poke attempts a
  // load and a restart while the core is busy.
  task automatic run_check(input string nm, input int stall_at, input bit poke);
    int k, halt_k, ne, shift;
    bit en_prev;
    logic [3:0] pc_frz;
    int got_edge[$];
    logic [7:0] got_val[$];
    halt_k = -1;
    pc_frz = '0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    k = 0;
    while (halt_k < 0 && k < 400) begin
      en_prev = ena;
      @(posedge clk);
      #1;
      k++;
      if (en_prev && out_valid) begin
        got_edge.push_back(k);
        got_val.push_back(out_data);
      end
      if (!en_prev) chk($sformatf("%s freeze@%0d", nm, k), {pc_dbg, busy, halted}, {pc_frz, 2'b10});
      if (poke && k == 1) begin
        load_we = 1'b1; load_addr = '0; load_data = 8'hE0; start = 1'b1;
      end
      if (poke && k == 3) begin
        load_we = 1'b0; start = 1'b0;
      end
      if (stall_at > 0 && k == stall_at) begin
        pc_frz = pc_dbg;
        ena = 1'b0;
      end
      if (stall_at > 0 && k == stall_at + 5) ena = 1'b1;
      if (halted) halt_k = k;
    end
    ne = exp_edge.size();
    chk($sformatf("%s strobe_count", nm), got_edge.size(), ne);
    for (int i = 0; i < ne && i < got_edge.size(); i++) begin
      shift = (stall_at > 0 && exp_edge[i] > stall_at) ? 5 : 0;
      chk($sformatf("%s out_data[%0d]", nm, i), got_val[i], exp_val[i]);
      chk($sformatf("%s strobe_edge[%0d]", nm, i), got_edge[i], exp_edge[i] + shift);
    end
    chk($sformatf("%s halt_edge", nm), halt_k, exp_halt_edge + ((stall_at > 0) ? 5 : 0));
    chk($sformatf("%s halt_pc", nm), pc_dbg, exp_halt_pc);
    chk($sformatf("%s busy_at_halt", nm), busy, 0);
  endtask

  task automatic put(input int v, input int a, input logic [7:0] w);
    tbl[v].prog[a] = w;
  endtask

  task automatic init_table();
    for (int v = 0; v < 6; v++) begin
      for (int a = 0; a < 16; a++) put(v, a, 8'hE0);
      tbl[v].outs = '0;
    end
    // LDI 1, ADD 2, OUT, HLT
    put(0, 0, 8'h41); put(0, 1, 8'h02); put(0, 2, 8'hC0);
    tbl[0].nout = 1; tbl[0].outs[0] = 8'd3; tbl[0].hpc = 3;
    // LDI 3, SUB 1, OUT, BNZ 1, HLT
    put(1, 0, 8'h43); put(1, 1, 8'h21); put(1, 2, 8'hC0); put(1, 3, 8'hA1);
    tbl[1].nout = 3; tbl[1].outs[0] = 8'd2; tbl[1].outs[1] = 8'd1; tbl[1].outs[2] = 8'd0;
    tbl[1].hpc = 4;
    // LDI 0, SUB 1, OUT, HLT  (wrap below zero)
    put(2, 0, 8'h40); put(2, 1, 8'h21); put(2, 2, 8'hC0);
    tbl[2].nout = 1; tbl[2].outs[0] = 8'hFF; tbl[2].hpc = 3;
    // LDI 31, ADD 31, ADD 31, OUT, HLT
    put(3, 0, 8'h5F); put(3, 1, 8'h1F); put(3, 2, 8'h1F); put(3, 3, 8'hC0);
    tbl[3].nout = 1; tbl[3].outs[0] = 8'd93; tbl[3].hpc = 4;
    // BZ 15 taken, LDI 7 at 15 wraps pc to 0, BZ not taken, OUT, HLT
    put(4, 0, 8'h8F); put(4, 1, 8'hC0); put(4, 15, 8'h47);
    tbl[4].nout = 1; tbl[4].outs[0] = 8'd7; tbl[4].hpc = 2;
    // JMP 19 (high operand bit ignored -> 3), LDI 5, OUT, JMP 2 -> HLT
    put(5, 0, 8'h73); put(5, 1, 8'hC0); put(5, 3, 8'h45); put(5, 4, 8'hC0); put(5, 5, 8'h62);
    tbl[5].nout = 1; tbl[5].outs[0] = 8'd5; tbl[5].hpc = 2;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int tgt, op;
    init_table();
    #12;
    chk("reset out_data", out_data, 0);
    chk("reset flags", {out_valid, busy, halted}, 0);
    chk("reset pc_dbg", pc_dbg, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      for (int a = 0; a < 16; a++) cur_prog[a] = tbl[v].prog[a];
      load_prog();
      model();
      exp_val.delete();
      for (int i = 0; i < int'(tbl[v].nout); i++) exp_val.push_back(tbl[v].outs[i]);
      exp_halt_pc = int'(tbl[v].hpc);
      run_check($sformatf("vec%0d", v), 0, 1'b0);
    end

    // Load and restart while busy are dropped/ignored; rerun is identical.
    for (int a = 0; a < 16; a++) cur_prog[a] = tbl[0].prog[a];
    load_prog();
    model();
    run_check("busy_poke", 0, 1'b1);
    run_check("rerun", 0, 1'b0);

    // Five-cycle ena drop in the EXEC of the second instruction.
    for (int a = 0; a < 16; a++) cur_prog[a] = tbl[1].prog[a];
    load_prog();
    model();
    run_check("stall", 3, 1'b0);

    // Asynchronous reset right as the first OUT strobes.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("pre_reset out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset outputs", {out_data, out_valid, busy, halted, pc_dbg}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_check("after_reset", 0, 1'b0);

    // Random forward-only programs ending in HLT at the last address.
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 15; a++) begin
        op = ($urandom_range(0, 19) == 0) ? 7 : int'($urandom_range(0, 6));
        if (op >= 3 && op <= 5) begin
          tgt = int'($urandom_range(a + 1, 15)) + 16 * int'($urandom_range(0, 1));
          cur_prog[a] = {3'(op), 5'(tgt)};
        end else begin
          cur_prog[a] = {3'(op), 5'($urandom_range(0, 31))};
        end
      end
      cur_prog[15] = 8'hE0;
      load_prog();
      model();
      run_check($sformatf("rand%0d", r), 0, 1'b0);
    end

`ifdef ACCUM_CORE_STEP_EN
    // One instruction per step pulse.
    for (int a = 0; a < 16; a++) cur_prog[a] = tbl[0].prog[a];
    load_prog();
    step_mode = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(posedge clk);
    for (int s = 1; s <= 3; s++) begin
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("step pause pc%0d", s), pc_dbg, s);
      chk($sformatf("step pause flags%0d", s), {busy, halted}, 0);
      step = 1'b1;
      @(posedge clk);
      #1 step = 1'b0;
      repeat (2) @(posedge clk);
    end
    #1;
    chk("step halted", halted, 1);
    chk("step out_data", out_data, 3);
    step_mode = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
